// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel countdown timer: FSM states,
// mode values, per-channel register offsets and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PSC  = 4;

  localparam int PSC_MAX_W = 8;
  // Channel field is always decoded at full width so unused indices never alias.
  localparam int CH_SEL_W  = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler and
// sequencing FSM.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | COUNT <= PRESET, prescaler cleared
// CNT   | counting down on prescaler ticks
// INT   | terminal count reached; reload or stop
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_ctrl,
  input  logic        we_preset,
  input  logic        we_count,
  input  logic        we_status,
  input  logic [31:0] din,
  output logic [31:0] ctrl_word,
  output logic [31:0] preset_word,
  output logic [31:0] count_word,
  output logic [31:0] status_word,
  output logic        irq
);

  localparam logic [7:0]       PSC_MASK = 8'((16'd1 << PSC_W) - 16'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic               en_q, im_q, pending_q;
  logic [1:0]         mode_q;
  logic [7:0]         psc_q, psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0]   preset_q, count_q, count_d;
  logic               set_pend, clr_en, stall;

  // STATUS writes only touch pending, so they do not stall the FSM;
  // that lets a coincident terminal count win over the W1C.
  assign stall = we_ctrl | we_preset | we_count;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    psc_cnt_d = psc_cnt_q;
    set_pend  = 1'b0;
    clr_en    = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_IDLE: if (en_q) state_d = ST_LOAD;
        ST_LOAD: begin
          count_d   = preset_q;
          psc_cnt_d = '0;
          state_d   = ST_CNT;
        end
        ST_CNT: begin
          if (!en_q) begin
            state_d = ST_IDLE;
          end else if (psc_cnt_q == psc_q) begin
            psc_cnt_d = '0;
            // PRESET of 0 lands here on the first tick, same as PRESET of 1.
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else begin
              count_d  = '0;
              set_pend = 1'b1;
              state_d  = ST_INT;
            end
          end else begin
            psc_cnt_d = psc_cnt_q + 8'd1;
          end
        end
        ST_INT: begin
          if (mode_q == MODE_RELOAD) begin
            state_d = ST_LOAD;
          end else begin
            clr_en  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      im_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      psc_q     <= '0;
      psc_cnt_q <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      psc_cnt_q <= psc_cnt_d;
      if (we_ctrl) begin
        en_q   <= din[CTRL_EN];
        mode_q <= din[CTRL_MODE +: 2];
        im_q   <= din[CTRL_IM];
        psc_q  <= din[CTRL_PSC +: PSC_MAX_W] & PSC_MASK;
      end else if (clr_en) begin
        en_q <= 1'b0;
      end
      if (we_preset) preset_q <= din[CNT_W-1:0];
      if (we_count)  count_q  <= din[CNT_W-1:0];
      if (set_pend) begin
        pending_q <= 1'b1;
      end else if (we_status && din[0]) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign ctrl_word   = {20'd0, psc_q, im_q, mode_q, en_q};
  assign preset_word = 32'(preset_q);
  assign count_word  = 32'(count_q);
  assign status_word = {26'd0, state_q, 3'd0, pending_q};
  assign irq         = pending_q & im_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel countdown timer on the word-addressed peripheral bus:
// address decode, read mux and combined interrupt.
module timer_multi
  import timer_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [N_CH-1:0] IRQ,
  output logic            IRQ_any
);

  logic [1:0]          reg_sel;
  logic [CH_SEL_W-1:0] ch_sel;
  logic [31:0]         rd_word [N_CH][4];
  logic                unused_addr;

  assign reg_sel     = Addr[3:2];
  assign ch_sel      = Addr[4 +: CH_SEL_W];
  assign unused_addr = ^Addr[31:7];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic        ch_we;
    logic [31:0] w_ctrl, w_preset, w_count, w_status;

    assign ch_we = WE && (ch_sel == CH_SEL_W'(i));

    timer_channel #(
      .CNT_W(CNT_W),
      .PSC_W(PSC_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .we_ctrl    (ch_we && (reg_sel == REG_CTRL)),
      .we_preset  (ch_we && (reg_sel == REG_PRESET)),
      .we_count   (ch_we && (reg_sel == REG_COUNT)),
      .we_status  (ch_we && (reg_sel == REG_STATUS)),
      .din        (Din),
      .ctrl_word  (w_ctrl),
      .preset_word(w_preset),
      .count_word (w_count),
      .status_word(w_status),
      .irq        (IRQ[i])
    );

    assign rd_word[i][0] = w_ctrl;
    assign rd_word[i][1] = w_preset;
    assign rd_word[i][2] = w_count;
    assign rd_word[i][3] = w_status;
  end

  always_comb begin
    Dout = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_SEL_W'(i)) Dout = rd_word[i][reg_sel];
    end
  end

  assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: register table vectors, then timed
// sequences for latency, auto-reload period, W1C races, disable and reset.
module tb_timer_multi;

  localparam int N_CH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:2]     Addr;
  logic            WE;
  logic [31:0]     Din;
  logic [31:0]     Dout;
  logic [N_CH-1:0] IRQ;
  logic            IRQ_any;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    int          ch;
    int          rsel;
    bit          do_wr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  timer_multi #(.N_CH(N_CH), .CNT_W(32), .PSC_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WE     (WE),
    .Din    (Din),
    .Dout   (Dout),
    .IRQ    (IRQ),
    .IRQ_any(IRQ_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_val(input string nm, input logic [31:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic compare(input logic [31:0] act);
    string nm;
    logic [31:0] ev;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      nm = name_q.pop_front();
      ev = exp_q.pop_front();
      if (act !== ev) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, act, ev);
      end
    end
  endtask

  task automatic set_addr(input int ch, input int r);
    Addr = '0;
    Addr[3:2] = 2'(r);
    Addr[6:4] = 3'(ch);
  endtask

  // Drives now; the write lands on the next rising edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    set_addr(ch, r);
    Din = d;
    WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd_cmp(input string nm, input int ch, input int r, input logic [31:0] e);
    expect_val(nm, e);
    @(negedge clk);
    set_addr(ch, r);
    WE = 1'b0;
    #1;
    compare(Dout);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 1000 && cyc < target; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input int ch, output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (IRQ[ch]) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s, s2, t;
    reset = 1'b1;
    WE = 1'b0;
    Addr = '0;
    Din = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    expect_val("reset_irq", 32'd0);     compare(32'(IRQ));
    expect_val("reset_irq_any", 32'd0); compare(32'(IRQ_any));

    // Reset readback, register masking and out-of-range channel decode.
    for (int r = 0; r < 4; r++) vecs.push_back('{0, r, 1'b0, 32'd0, 32'd0});
    for (int r = 0; r < 4; r++) vecs.push_back('{1, r, 1'b0, 32'd0, 32'd0});
    vecs.push_back('{3, 0, 1'b0, 32'd0,         32'd0});
    vecs.push_back('{0, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0FFE});
    vecs.push_back('{0, 0, 1'b1, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{0, 1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{0, 2, 1'b1, 32'h1234_5678, 32'h1234_5678});
    vecs.push_back('{0, 3, 1'b1, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{3, 0, 1'b1, 32'h0000_000F, 32'h0000_0000});
    vecs.push_back('{1, 0, 1'b0, 32'd0,         32'h0000_0000});
    vecs.push_back('{3, 1, 1'b1, 32'h0000_0005, 32'h0000_0000});
    vecs.push_back('{1, 1, 1'b0, 32'd0,         32'h0000_0000});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_wr) wr(vecs[i].ch, vecs[i].rsel, vecs[i].din);
      rd_cmp($sformatf("vec%0d", i), vecs[i].ch, vecs[i].rsel, vecs[i].exp);
    end

    // One-shot, IM=1, PSC=0, PRESET=5.
    wr(0, 1, 32'd5);
    wr(0, 0, 32'h9);
    e0 = cyc;
    expect_val("oneshot_latency", 32'(e0 + 7));
    wait_irq(0, t);
    compare(32'(t));
    rd_cmp("oneshot_count", 0, 2, 32'd0);
    rd_cmp("oneshot_ctrl_en_cleared", 0, 0, 32'h8);
    expect_val("oneshot_irq_sticky", 32'd1); compare(32'(IRQ[0]));
    wr(0, 3, 32'h1);
    expect_val("oneshot_irq_cleared", 32'd0); compare(32'(IRQ[0]));
    expect_val("oneshot_irq_any_low", 32'd0); compare(32'(IRQ_any));

    // Auto-reload on ch1, PSC=1, PRESET=3.
    wr(1, 1, 32'd3);
    wr(1, 0, 32'h1B);
    e0 = cyc;
    expect_val("reload_first", 32'(e0 + 8));
    wait_irq(1, s);
    compare(32'(s));
    wr(1, 3, 32'h1);
    expect_val("reload_period", 32'(s + 8));
    wait_irq(1, s2);
    compare(32'(s2));
    wr(1, 3, 32'h1);
    expect_val("reload_cleared", 32'd0); compare(32'(IRQ[1]));
    rd_cmp("ch0_status_untouched", 0, 3, 32'd0);
    rd_cmp("ch0_count_untouched", 0, 2, 32'd0);
    // W1C lands on the same edge as the next terminal count.
    wait_cyc(s2 + 7);
    wr(1, 3, 32'h1);
    expect_val("set_beats_w1c", 32'd1); compare(32'(IRQ[1]));
    rd_cmp("set_beats_w1c_status", 1, 3, 32'h31);
    wr(1, 0, 32'h0);
    wr(1, 3, 32'h1);
    expect_val("ch1_stopped_irq", 32'd0); compare(32'(IRQ[1]));

    // IM=0: pending sets, IRQ stays low until IM is written.
    wr(0, 1, 32'd4);
    wr(0, 0, 32'h1);
    e0 = cyc;
    wait_cyc(e0 + 8);
    rd_cmp("masked_pending", 0, 3, 32'h01);
    expect_val("masked_irq_low", 32'd0); compare(32'(IRQ[0]));
    wr(0, 0, 32'h8);
    expect_val("unmask_irq", 32'd1); compare(32'(IRQ[0]));
    expect_val("unmask_irq_any", 32'd1); compare(32'(IRQ_any));
    wr(0, 3, 32'h1);

    // EN cleared mid-count, then re-enabled with a new PRESET.
    wr(0, 1, 32'd6);
    wr(0, 0, 32'h1);
    e0 = cyc;
    wait_cyc(e0 + 6);
    rd_cmp("midcount_count2", 0, 2, 32'd2);
    wr(0, 0, 32'h0);
    e0 = cyc;
    wait_cyc(e0 + 2);
    rd_cmp("disabled_idle", 0, 3, 32'h00);
    rd_cmp("disabled_count_holds", 0, 2, 32'd2);
    wr(0, 1, 32'd9);
    wr(0, 0, 32'h1);
    e0 = cyc;
    wait_cyc(e0 + 2);
    rd_cmp("reenable_reload", 0, 2, 32'd9);
    rd_cmp("reenable_state_cnt", 0, 3, 32'h20);
    wr(0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // PRESET=0 counts as 1.
    wr(0, 1, 32'd0);
    wr(0, 0, 32'h9);
    e0 = cyc;
    expect_val("preset0_latency", 32'(e0 + 3));
    wait_irq(0, t);
    compare(32'(t));
    wr(0, 3, 32'h1);
    expect_val("preset0_cleared", 32'd0); compare(32'(IRQ[0]));

    // Reset while ch1 is counting.
    wr(1, 1, 32'd10);
    wr(1, 0, 32'h1B);
    e0 = cyc;
    wait_cyc(e0 + 5);
    rd_cmp("pre_reset_count", 1, 2, 32'd9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_cmp("post_reset_ctrl", 1, 0, 32'd0);
    rd_cmp("post_reset_preset", 1, 1, 32'd0);
    rd_cmp("post_reset_count", 1, 2, 32'd0);
    rd_cmp("post_reset_status", 1, 3, 32'd0);
    expect_val("post_reset_irq", 32'd0); compare(32'(IRQ));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
